// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control sequencer: state encodings,
// the PC increment and the register-index width helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Sequential instructions advance the PC by one 32-bit word.
  localparam int PC_STEP = 4;

  // Width of a register index for a file of nregs entries (at least 1 bit).
  function automatic int reg_idx_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/gpr_file.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero, whole array cleared on reset.
module gpr_file
  import cpu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wen,
  input  logic [reg_idx_w(NREGS)-1:0] i_waddr,
  input  logic [XLEN-1:0]             i_wdata,
  input  logic [reg_idx_w(NREGS)-1:0] i_raddr1,
  output logic [XLEN-1:0]             o_rdata1,
  input  logic [reg_idx_w(NREGS)-1:0] i_raddr2,
  output logic [XLEN-1:0]             o_rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  // Clear every entry on reset, otherwise accept one write per cycle (never to r0).
  // NOTE: the array is deliberately reset; software expects every GPR to read
  // zero after reset, so this storage cannot be left uninitialised like a RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (i_wen && (i_waddr != '0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : regs[i_raddr2];

endmodule

// File: rtl/cpu_seq.sv
// Multicycle CPU control sequencer: FETCH / DECODE / EXEC / WB with a
// variable-latency memory handshake, owned PC and GPRs, branch redirect,
// illegal-instruction and misaligned-fetch trap, and a sticky halt.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ADDR_W   = 14,
  parameter int              NREGS    = 32,
  parameter int              INSN_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  output logic                        o_mem_req,
  output logic [ADDR_W-1:0]           o_mem_addr,
  input  logic                        i_mem_ack,
  input  logic [INSN_W-1:0]           i_mem_data,
  output logic [INSN_W-1:0]           o_insn,
  input  logic                        i_dcd_valid,
  input  logic                        i_dcd_halt,
  input  logic                        i_dcd_wen,
  input  logic [reg_idx_w(NREGS)-1:0] i_dcd_rd,
  input  logic [reg_idx_w(NREGS)-1:0] i_dcd_rs1,
  input  logic [reg_idx_w(NREGS)-1:0] i_dcd_rs2,
  output logic [XLEN-1:0]             o_rs1_val,
  output logic [XLEN-1:0]             o_rs2_val,
  output logic                        o_ex_start,
  input  logic                        i_ex_done,
  input  logic [XLEN-1:0]             i_ex_result,
  input  logic                        i_ex_branch,
  input  logic [XLEN-1:0]             i_ex_target,
  output logic [XLEN-1:0]             o_pc,
  output logic [2:0]                  o_state,
  output logic                        o_halted,
  output logic                        o_trap
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ex_result;
  logic            ex_branch;
  logic [XLEN-1:0] ex_target;
  logic            pc_aligned;
  logic            wb_wen;

  assign pc_aligned = (pc[1:0] == 2'b00);
  // Decoder outputs are stable from DECODE to WB, so rd/wen are taken live here.
  assign wb_wen     = (state == ST_WB) && i_dcd_wen && (i_dcd_rd != '0);

  // The request is a decode of state so it is already high in the first FETCH
  // cycle; it stays low while reset is asserted and for a misaligned PC.
  assign o_mem_req  = !i_rst && (state == ST_FETCH) && pc_aligned;
  assign o_mem_addr = pc[ADDR_W-1:0];
  assign o_pc       = pc;
  assign o_state    = state;

  gpr_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_gpr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wen    (wb_wen),
    .i_waddr  (i_dcd_rd),
    .i_wdata  (ex_result),
    .i_raddr1 (i_dcd_rs1),
    .o_rdata1 (o_rs1_val),
    .i_raddr2 (i_dcd_rs2),
    .o_rdata2 (o_rs2_val)
  );

  // Sequencer FSM with registered instruction, execute start pulse, PC and sticky flags.
  // NOTE: non-blocking assignments everywhere here so each register sees the
  // pre-edge value of its peers, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      o_insn     <= '0;
      o_ex_start <= 1'b0;
      o_halted   <= 1'b0;
      o_trap     <= 1'b0;
      ex_result  <= '0;
      ex_branch  <= 1'b0;
      ex_target  <= '0;
    end else begin
      o_ex_start <= 1'b0;
      unique case (state)
        ST_FETCH: begin
          if (!pc_aligned) begin
            state  <= ST_TRAP;
            o_trap <= 1'b1;
          end else if (i_mem_ack) begin
            o_insn <= i_mem_data;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (i_dcd_halt) begin
            state    <= ST_HALT;
            o_halted <= 1'b1;
          end else if (!i_dcd_valid) begin
            state  <= ST_TRAP;
            o_trap <= 1'b1;
          end else begin
            o_ex_start <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (i_ex_done) begin
            ex_result <= i_ex_result;
            ex_branch <= i_ex_branch;
            ex_target <= i_ex_target;
            state     <= ST_WB;
          end
        end
        ST_WB: begin
          pc    <= ex_branch ? ex_target : pc + XLEN'(PC_STEP);
          state <= ST_FETCH;
        end
        ST_HALT, ST_TRAP: begin
          state <= state;
        end
        default: begin
          state  <= ST_TRAP;
          o_trap <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: a table of hand-computed instruction
// vectors, hand-written multicycle corner sequences, and a randomized run
// checked against an instruction-level reference model.
module tb_cpu_seq;
  import cpu_pkg::*;

  localparam int              XLEN    = 64;
  localparam int              ADDR_W  = 14;
  localparam int              NREGS   = 32;
  localparam int              INSN_W  = 32;
  localparam int              RW      = 5;
  localparam logic [XLEN-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_ack = 1'b0;
  logic [INSN_W-1:0] mem_data = '0;
  logic              dcd_valid = 1'b1, dcd_halt = 1'b0, dcd_wen = 1'b0;
  logic [RW-1:0]     dcd_rd = '0, dcd_rs1 = '0, dcd_rs2 = '0;
  logic              ex_done = 1'b0, ex_branch = 1'b0;
  logic [XLEN-1:0]   ex_result = '0, ex_target = '0;

  logic              mem_req, ex_start, halted, trap;
  logic [ADDR_W-1:0] mem_addr;
  logic [INSN_W-1:0] insn;
  logic [XLEN-1:0]   rs1_val, rs2_val, pc;
  logic [2:0]        state;

  logic              w_mem_req, w_ex_start, w_halted, w_trap;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [INSN_W-1:0] w_insn;
  logic [XLEN-1:0]   w_rs1_val, w_rs2_val, w_pc;
  logic [2:0]        w_state;

  always #5 clk = ~clk;

  cpu_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NREGS(NREGS), .INSN_W(INSN_W), .RESET_PC('0)) u_dut (
    .i_clk(clk), .i_rst(rst), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_data(mem_data), .o_insn(insn),
    .i_dcd_valid(dcd_valid), .i_dcd_halt(dcd_halt), .i_dcd_wen(dcd_wen),
    .i_dcd_rd(dcd_rd), .i_dcd_rs1(dcd_rs1), .i_dcd_rs2(dcd_rs2),
    .o_rs1_val(rs1_val), .o_rs2_val(rs2_val), .o_ex_start(ex_start),
    .i_ex_done(ex_done), .i_ex_result(ex_result), .i_ex_branch(ex_branch),
    .i_ex_target(ex_target), .o_pc(pc), .o_state(state),
    .o_halted(halted), .o_trap(trap)
  );

  // Second instance reset near the top of the address space, same stimulus.
  cpu_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NREGS(NREGS), .INSN_W(INSN_W), .RESET_PC(WRAP_PC)) u_wrap (
    .i_clk(clk), .i_rst(rst), .o_mem_req(w_mem_req), .o_mem_addr(w_mem_addr),
    .i_mem_ack(mem_ack), .i_mem_data(mem_data), .o_insn(w_insn),
    .i_dcd_valid(dcd_valid), .i_dcd_halt(dcd_halt), .i_dcd_wen(dcd_wen),
    .i_dcd_rd(dcd_rd), .i_dcd_rs1(dcd_rs1), .i_dcd_rs2(dcd_rs2),
    .o_rs1_val(w_rs1_val), .o_rs2_val(w_rs2_val), .o_ex_start(w_ex_start),
    .i_ex_done(ex_done), .i_ex_result(ex_result), .i_ex_branch(ex_branch),
    .i_ex_target(ex_target), .o_pc(w_pc), .o_state(w_state),
    .o_halted(w_halted), .o_trap(w_trap)
  );

  typedef struct {
    logic [INSN_W-1:0] word;
    bit                valid;
    bit                halt;
    bit                wen;
    logic [RW-1:0]     rd;
    logic [XLEN-1:0]   result;
    bit                branch;
    logic [XLEN-1:0]   target;
  } insn_t;

  typedef struct {
    insn_t           t;
    int              mw;      // memory wait states
    int              ew;      // execute wait cycles
    bit              stray;   // inject stray ack/done
    logic [XLEN-1:0] exp_pc;
    state_t          exp_state;
    logic [RW-1:0]   chk_reg;
    logic [XLEN-1:0] exp_reg;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction-level reference model.
  logic [XLEN-1:0]   m_pc;
  logic [XLEN-1:0]   m_regs [NREGS];
  logic [INSN_W-1:0] m_insn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic insn_t mk(input logic [INSN_W-1:0] word, input bit valid, input bit halt,
                               input bit wen, input logic [RW-1:0] rd, input logic [XLEN-1:0] result,
                               input bit branch, input logic [XLEN-1:0] target);
    insn_t t;
    t.word = word; t.valid = valid; t.halt = halt; t.wen = wen;
    t.rd = rd; t.result = result; t.branch = branch; t.target = target;
    return t;
  endfunction

  function automatic void model_reset(input logic [XLEN-1:0] rpc);
    m_pc = rpc;
    m_insn = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
  endfunction

  // Hold reset for a few cycles, check reset values and that every GPR reads zero.
  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; ex_done = 1'b0;
    tick();
    check("rst_state", state, ST_FETCH);
    check("rst_pc", pc, 64'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ex_start", ex_start, 1'b0);
    check("rst_insn", insn, '0);
    check("rst_halted", halted, 1'b0);
    check("rst_trap", trap, 1'b0);
    check("rst_wrap_pc", w_pc, WRAP_PC);
    for (int i = 0; i < NREGS; i++) begin
      dcd_rs1 = RW'(i);
      dcd_rs2 = RW'(NREGS - 1 - i);
      tick();
      check("rst_gpr_rs1", rs1_val, '0);
      check("rst_gpr_rs2", rs2_val, '0);
    end
    rst = 1'b0;
    #1;
    model_reset('0);
  endtask

  // Run one instruction from its first FETCH cycle, checking every cycle against the model.
  task automatic do_insn(input insn_t t, input int mw, input int ew, input bit stray);
    logic [XLEN-1:0] fpc;
    logic [RW-1:0]   r2;
    fpc = m_pc;
    dcd_valid = t.valid; dcd_halt = t.halt; dcd_wen = t.wen; dcd_rd = t.rd;
    if (fpc[1:0] != 2'b00) begin
      check("mis_req", mem_req, 1'b0);
      tick();
      check("mis_state", state, ST_TRAP);
      check("mis_trap", trap, 1'b1);
      check("mis_pc", pc, fpc);
      check("mis_req_after", mem_req, 1'b0);
      return;
    end
    for (int k = 0; k <= mw; k++) begin
      check("fetch_req", mem_req, 1'b1);
      check("fetch_addr", mem_addr, fpc[ADDR_W-1:0]);
      mem_ack  = (k == mw);
      mem_data = (k == mw) ? t.word : $urandom;
      tick();
      if (k < mw) begin
        check("fetch_wait_state", state, ST_FETCH);
        check("fetch_insn_hold", insn, m_insn);
      end
    end
    mem_ack = 1'b0;
    m_insn  = t.word;
    check("dec_state", state, ST_DECODE);
    check("dec_insn", insn, t.word);
    check("dec_req", mem_req, 1'b0);
    dcd_rs1 = t.rd;
    ex_done = stray; ex_result = ~t.result; ex_branch = ~t.branch; ex_target = ~t.target;
    tick();
    ex_done = 1'b0;
    if (t.halt) begin
      check("halt_state", state, ST_HALT);
      check("halt_flag", halted, 1'b1);
      check("halt_pc", pc, fpc);
      return;
    end
    if (!t.valid) begin
      check("ill_state", state, ST_TRAP);
      check("ill_trap", trap, 1'b1);
      check("ill_pc", pc, fpc);
      return;
    end
    check("exec_state", state, ST_EXEC);
    check("exec_start", ex_start, 1'b1);
    for (int k = 0; k <= ew; k++) begin
      if (k > 0) begin
        check("exec_wait_state", state, ST_EXEC);
        check("exec_start_pulse", ex_start, 1'b0);
      end
      ex_done   = (k == ew);
      ex_result = (k == ew) ? t.result : {$urandom, $urandom};
      ex_branch = (k == ew) ? t.branch : 1'($urandom);
      ex_target = (k == ew) ? t.target : {$urandom, $urandom};
      mem_ack   = stray && (k == 0);
      mem_data  = $urandom;
      tick();
    end
    ex_done = 1'b0; mem_ack = 1'b0;
    ex_result = {$urandom, $urandom}; ex_branch = ~t.branch; ex_target = {$urandom, $urandom};
    r2 = RW'($urandom_range(0, NREGS - 1));
    dcd_rs2 = r2;
    #1;
    check("wb_state", state, ST_WB);
    check("wb_insn", insn, t.word);
    check("wb_pc", pc, fpc);
    check("wb_rd_old", rs1_val, m_regs[t.rd]);
    check("wb_rs2", rs2_val, m_regs[r2]);
    if (t.wen && t.rd != '0) m_regs[t.rd] = t.result;
    m_pc = t.branch ? t.target : m_pc + 64'd4;
    tick();
    check("next_state", state, ST_FETCH);
    check("next_pc", pc, m_pc);
    check("next_rd_new", rs1_val, m_regs[t.rd]);
  endtask

  // Frozen terminal state: random stray inputs must change nothing.
  task automatic frozen(input int n, input state_t st, input logic [XLEN-1:0] pc_exp);
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'($urandom); ex_done = 1'($urandom); mem_data = $urandom;
      dcd_valid = 1'($urandom); dcd_halt = 1'($urandom);
      ex_branch = 1'($urandom); ex_target = {$urandom, $urandom};
      tick();
      check("frozen_state", state, st);
      check("frozen_pc", pc, pc_exp);
      check("frozen_halted", halted, st == ST_HALT);
      check("frozen_trap", trap, st == ST_TRAP);
      check("frozen_req", mem_req, 1'b0);
    end
    mem_ack = 1'b0; ex_done = 1'b0;
  endtask

  vec_t  vecs [5];
  insn_t ti;

  initial begin
    vecs[0] = '{t: mk(32'h0031_8133, 1, 0, 1, 5'd3, 64'h5, 0, '0), mw: 0, ew: 0, stray: 0,
                exp_pc: 64'h4, exp_state: ST_FETCH, chk_reg: 5'd3, exp_reg: 64'h5};
    vecs[1] = '{t: mk(32'h0000_0033, 1, 0, 1, 5'd0, 64'hFFFF, 0, '0), mw: 3, ew: 2, stray: 1,
                exp_pc: 64'h8, exp_state: ST_FETCH, chk_reg: 5'd0, exp_reg: 64'h0};
    vecs[2] = '{t: mk(32'h0400_0063, 1, 0, 1, 5'd7, 64'hAB, 1, 64'h40), mw: 1, ew: 0, stray: 1,
                exp_pc: 64'h40, exp_state: ST_FETCH, chk_reg: 5'd7, exp_reg: 64'hAB};
    vecs[3] = '{t: mk(32'h0000_0013, 1, 0, 0, 5'd3, 64'h99, 0, '0), mw: 2, ew: 3, stray: 0,
                exp_pc: 64'h44, exp_state: ST_FETCH, chk_reg: 5'd3, exp_reg: 64'h5};
    vecs[4] = '{t: mk(32'h0010_0073, 1, 1, 0, 5'd0, 64'h0, 0, '0), mw: 0, ew: 0, stray: 0,
                exp_pc: 64'h44, exp_state: ST_HALT, chk_reg: 5'd7, exp_reg: 64'hAB};

    // PC wrap: the second instance starts at 2^64-4 and steps to 0.
    do_reset();
    check("wrap_addr0", w_mem_addr, 14'h3FFC);
    do_insn(mk(32'h13, 1, 0, 1, 5'd1, 64'h11, 0, '0), 0, 0, 0);
    check("wrap_pc", w_pc, 64'h0);
    check("wrap_addr", w_mem_addr, 14'h0);
    check("wrap_state", w_state, ST_FETCH);

    // Table-driven program ending in HALT.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_insn(vecs[i].t, vecs[i].mw, vecs[i].ew, vecs[i].stray);
      dcd_rs1 = vecs[i].chk_reg;
      #1;
      check("vec_pc", pc, vecs[i].exp_pc);
      check("vec_state", state, vecs[i].exp_state);
      check("vec_reg", rs1_val, vecs[i].exp_reg);
    end
    frozen(10, ST_HALT, 64'h44);

    // Branch to a misaligned target: no request, trap holding the faulting PC.
    do_reset();
    do_insn(mk(32'h0420_0063, 1, 0, 0, 5'd0, 64'h0, 1, 64'h42), 0, 1, 0);
    check("mis_branch_pc", pc, 64'h42);
    do_insn(mk(32'h13, 1, 0, 0, 5'd0, 64'h0, 0, '0), 0, 0, 0);
    frozen(100, ST_TRAP, 64'h42);

    // Illegal instruction traps at its own PC.
    do_reset();
    do_insn(mk(32'h13, 1, 0, 1, 5'd2, 64'h22, 0, '0), 0, 0, 0);
    do_insn(mk(32'hFFFF_FFFF, 0, 0, 1, 5'd2, 64'h33, 0, '0), 1, 0, 0);
    frozen(5, ST_TRAP, 64'h4);

    // Reset asserted in EXEC together with done: result is discarded.
    do_reset();
    dcd_valid = 1'b1; dcd_halt = 1'b0; dcd_wen = 1'b1; dcd_rd = 5'd5; dcd_rs1 = 5'd5;
    mem_ack = 1'b1; mem_data = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    check("rx_dec", state, ST_DECODE);
    tick();
    check("rx_exec", state, ST_EXEC);
    ex_done = 1'b1; ex_result = 64'h77; ex_branch = 1'b1; ex_target = 64'h80; rst = 1'b1;
    tick();
    ex_done = 1'b0; rst = 1'b0;
    #1;
    check("rx_state", state, ST_FETCH);
    check("rx_pc", pc, 64'h0);
    check("rx_insn", insn, '0);
    check("rx_req", mem_req, 1'b1);
    tick();
    check("rx_state2", state, ST_FETCH);
    check("rx_pc2", pc, 64'h0);
    check("rx_gpr5", rs1_val, 64'h0);
    model_reset('0);

    // Randomized program against the reference model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      ti = mk($urandom, 1, 0, 1'($urandom), RW'($urandom_range(0, NREGS - 1)),
              {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
              {$urandom, $urandom} & ~64'h3);
      do_insn(ti, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    ti = mk(32'h0010_0073, 1, 1, 0, 5'd0, 64'h0, 0, '0);
    do_insn(ti, 1, 0, 0);
    frozen(4, ST_HALT, m_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
